// File: rtl/div_result_stage.sv
// div_result_stage: registered result stage with a 2-entry skid buffer behind the 16/8 array divider.
// Define DIV_RESIDUAL_EN to add the squared-residual accumulator and sample counter.
module div_result_stage #(
  parameter int CNT_W  = 16,
  parameter int SAT_DZ = 1,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_n,
  input  logic [7:0]        in_d,
  input  logic [7:0]        in_q,
  input  logic [7:0]        in_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_q,
  output logic [7:0]        out_r,
  output logic              out_dz,
  output logic              out_ovf,
`ifdef DIV_RESIDUAL_EN
  output logic [ACC_W-1:0]  err_sq_acc,
  output logic [31:0]       sample_count,
`endif
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } entry_t;

  occ_e             state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_s;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             accept_s;
  logic             pop_s;

  assign accept_s = in_valid & in_ready_q;
  assign pop_s    = out_valid_q & out_ready;

  // Flag and substitute the incoming divider result
  always_comb begin
    new_s.dz  = (in_d == 8'd0);
    new_s.ovf = (in_d != 8'd0) && (in_n[15:8] >= in_d);
    if (new_s.dz && (SAT_DZ != 0)) begin
      new_s.q = 8'hFF;
      new_s.r = in_n[7:0];
    end else begin
      new_s.q = in_q;
      new_s.r = in_r;
    end
  end

  // Occupancy FSM: main register feeds the outputs, skid holds the second entry
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          main_d  = new_s;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && !pop_s) begin
          skid_d  = new_s;
          state_d = TWO;
        end else if (accept_s && pop_s) begin
          main_d  = new_s;
          state_d = ONE;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          main_d  = skid_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // Saturating overflow event counter
  always_comb begin
    if (accept_s && new_s.ovf && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  // Buffer, handshake and counter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_q     = main_q.q;
  assign out_r     = main_q.r;
  assign out_dz    = main_q.dz;
  assign out_ovf   = main_q.ovf;
  assign ovf_count = ovf_count_q;

`ifdef DIV_RESIDUAL_EN
  logic [16:0]    prod_sum_s;
  logic [16:0]    e_abs_s;
  logic [33:0]    e_sq_s;
  logic [ACC_W:0] acc_sum_s;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]    cnt_q, cnt_d;

  // Residual magnitude of the raw divider result; sign is irrelevant once squared
  always_comb begin
    prod_sum_s = ({9'd0, in_q} * {9'd0, in_d}) + {9'd0, in_r};
    if ({1'b0, in_n} >= prod_sum_s) begin
      e_abs_s = {1'b0, in_n} - prod_sum_s;
    end else begin
      e_abs_s = prod_sum_s - {1'b0, in_n};
    end
    e_sq_s    = {17'd0, e_abs_s} * {17'd0, e_abs_s};
    acc_sum_s = {1'b0, acc_q} + {{(ACC_W-33){1'b0}}, e_sq_s};
  end

  // Saturating accumulate on non-zero-divisor transfers; sample counter wraps
  always_comb begin
    if (accept_s && !new_s.dz) begin
      acc_d = acc_sum_s[ACC_W] ? {ACC_W{1'b1}} : acc_sum_s[ACC_W-1:0];
    end else begin
      acc_d = acc_q;
    end
    if (accept_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Residual statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= 32'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_sq_acc   = acc_q;
  assign sample_count = cnt_q;
`endif

endmodule

// File: tb/tb_div_result_stage.sv
// Self-checking bench for div_result_stage: vector table with a scoreboard, plus
// backpressure and mid-stream reset sequences.
module tb_div_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_n;
  logic [7:0]  in_d, in_q, in_r;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_q, out_r;
  logic        out_dz, out_ovf;
  logic [15:0] ovf_count;
`ifdef DIV_RESIDUAL_EN
  logic [47:0] err_sq_acc;
  logic [31:0] sample_count;
`endif

  always #5 clk = ~clk;

  div_result_stage #(.CNT_W(16), .SAT_DZ(1), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_d(in_d), .in_q(in_q), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_ovf(out_ovf),
`ifdef DIV_RESIDUAL_EN
    .err_sq_acc(err_sq_acc), .sample_count(sample_count),
`endif
    .ovf_count(ovf_count)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    exp_t        e;
    longint      sq;
  } vec_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  vec_t   vecs[8];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: compare the head entry whenever the next edge pops the output
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=q%0d/r%0d required=no_output", out_q, out_r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_q", out_q, e.q);
        chk("out_r", out_r, e.r);
        chk("out_dz", out_dz, e.dz);
        chk("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  task automatic send(input logic [15:0] n, input logic [7:0] d, input logic [7:0] q,
                      input logic [7:0] r, input exp_t e);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_n = n; in_d = d; in_q = q; in_r = r;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      waited++;
      if (waited > 40) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=not_accepted required=accepted");
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
  endtask

  initial begin
    int   exp_ovf_cnt;
    longint exp_acc;
    exp_t ea, eb, ec, eo;

    vecs[0] = '{16'd100,  8'd7,   8'd14,  8'd2,  '{8'd14,  8'd2,  1'b0, 1'b0}, 0};
    vecs[1] = '{16'd100,  8'd7,   8'd13,  8'd2,  '{8'd13,  8'd2,  1'b0, 1'b0}, 49};
    vecs[2] = '{16'h1234, 8'd0,   8'h00,  8'h55, '{8'hFF,  8'h34, 1'b1, 1'b0}, 0};
    vecs[3] = '{16'h0900, 8'd9,   8'h00,  8'h00, '{8'h00,  8'h00, 1'b0, 1'b1}, 5308416};
    vecs[4] = '{16'h08FF, 8'd9,   8'hFF,  8'h08, '{8'hFF,  8'h08, 1'b0, 1'b0}, 0};
    vecs[5] = '{16'hFFFF, 8'd255, 8'h01,  8'h00, '{8'h01,  8'h00, 1'b0, 1'b1}, 64'd4261478400};
    vecs[6] = '{16'h00FF, 8'd1,   8'hFF,  8'h00, '{8'hFF,  8'h00, 1'b0, 1'b0}, 0};
    vecs[7] = '{16'h0100, 8'd1,   8'h00,  8'h00, '{8'h00,  8'h00, 1'b0, 1'b1}, 65536};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_n = 16'd0; in_d = 8'd0; in_q = 8'd0; in_r = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_flags", {out_dz, out_ovf}, 0);
    chk("rst_ovf_count", ovf_count, 0);
`ifdef DIV_RESIDUAL_EN
    chk("rst_err_sq_acc", err_sq_acc, 0);
    chk("rst_sample_count", sample_count, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_ovf_cnt = 0;
    exp_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].e);
      if (vecs[i].e.ovf) exp_ovf_cnt++;
      exp_acc += vecs[i].sq;
      if (i == 0) chk("first_latency_valid", out_valid, 1);
      chk("ovf_count", ovf_count, exp_ovf_cnt);
`ifdef DIV_RESIDUAL_EN
      chk("err_sq_acc", err_sq_acc, exp_acc);
      chk("sample_count", sample_count, i + 1);
`endif
    end
    wait_drain();
    @(posedge clk); #1;
    chk("idle_out_valid", out_valid, 0);

    // Backpressure: A and B fill the buffer, C waits
    ea = '{8'd14, 8'd2, 1'b0, 1'b0};
    eb = '{8'd22, 8'd2, 1'b0, 1'b0};
    ec = '{8'd10, 8'd0, 1'b0, 1'b0};
    out_ready = 1'b0;
    send(16'd100, 8'd7, 8'd14, 8'd2, ea);
    chk("bp_a_valid", out_valid, 1);
    send(16'd200, 8'd9, 8'd22, 8'd2, eb);
    chk("bp_full_in_ready", in_ready, 0);
    fork
      send(16'd50, 8'd5, 8'd10, 8'd0, ec);
    join_none
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_q", out_q, 14);
      chk("bp_hold_r", out_r, 2);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    wait_drain();
    @(posedge clk); #1;
    chk("bp_end_out_valid", out_valid, 0);

    // Mid-stream reset with two overflow results buffered
    eo = '{8'h00, 8'h00, 1'b0, 1'b1};
    out_ready = 1'b0;
    send(16'h0900, 8'd9, 8'h00, 8'h00, eo);
    send(16'h0100, 8'd1, 8'h00, 8'h00, eo);
    chk("pre_rst_ovf_count", ovf_count, 5);
    chk("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ovf_count", ovf_count, 0);
    chk("mid_rst_out_q", out_q, 0);
`ifdef DIV_RESIDUAL_EN
    chk("mid_rst_err_sq_acc", err_sq_acc, 0);
    chk("mid_rst_sample_count", sample_count, 0);
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_stale", out_valid, 0);
    send(16'd100, 8'd7, 8'd14, 8'd2, ea);
    wait_drain();
    chk("post_rst_ovf_count", ovf_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
